// File: rtl/dcache_ctrl_wb.sv
// Write-back, write-allocate L1 data cache controller: stalls on a miss, writes back a dirty victim,
// refills the block and replays the held request. Define DCACHE_PERF_CNT_EN to add perf counters.
module dcache_ctrl_wb #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned BLOCK_WORDS = 4,
  localparam int unsigned BLOCK_BYTES = WORD_BYTES * BLOCK_WORDS,
  localparam int unsigned BLOCK_BITS  = 8 * BLOCK_BYTES,
  localparam int unsigned OFF_W       = $clog2(BLOCK_BYTES),
  localparam int unsigned BADDR_W     = ADDR_W - OFF_W,
  localparam int unsigned WORD_W      = 8 * WORD_BYTES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ren,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WORD_BYTES-1:0]  byteSelectVector,
  input  logic [WORD_W-1:0]      din,
  output logic                   stall,
  output logic [WORD_W-1:0]      dout,
  input  logic                   cacheHit,
  input  logic                   cacheDirtyBit,
  input  logic [BADDR_W-1:0]     cacheVictimBAddr,
  input  logic [BLOCK_BITS-1:0]  cacheDout,
  output logic                   cacheEn,
  output logic                   cacheWen,
  output logic                   cacheFullBlockWen,
  output logic                   cacheSetDirty,
  output logic [BLOCK_BYTES-1:0] cacheBytesAccess,
  output logic [BLOCK_BITS-1:0]  cacheDin,
  output logic                   memRen,
  output logic                   memWen,
  output logic [BADDR_W-1:0]     memBlockAddr,
  output logic [BLOCK_BITS-1:0]  memDin,
  input  logic                   memReadReady,
  input  logic                   memWriteDone,
  input  logic [BLOCK_BITS-1:0]  memDout
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]            perfHits,
  output logic [31:0]            perfMisses,
  output logic [31:0]            perfWritebacks
`endif
);

  localparam int unsigned WOFF_W = $clog2(WORD_BYTES);
  localparam int unsigned IDX_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWriteback, StMemread, StFill} state_e;

  state_e                state_q;
  logic [BADDR_W-1:0]    req_baddr_q;
  logic [BADDR_W-1:0]    victim_baddr_q;
  logic [BLOCK_BITS-1:0] victim_data_q;
  logic [BLOCK_BITS-1:0] fill_data_q;

  logic                   req;
  logic [IDX_W-1:0]       word_idx;
  logic [WORD_W-1:0]      hit_word;
  logic [BLOCK_BYTES-1:0] hit_mask;

  // A request seen while reset is held must not drive the array or stall.
  assign req = (ren | wen) & ~reset;

  if (BLOCK_WORDS > 1) begin : g_word_idx
    assign word_idx = addr[OFF_W-1:WOFF_W];
  end else begin : g_word_idx_single
    assign word_idx = '0;
  end

  assign hit_word = cacheDout[WORD_W*word_idx +: WORD_W];
  assign hit_mask = BLOCK_BYTES'(byteSelectVector) << (WORD_BYTES * word_idx);

  always_comb begin
    stall             = 1'b0;
    dout              = '0;
    cacheEn           = 1'b0;
    cacheWen          = 1'b0;
    cacheFullBlockWen = 1'b0;
    cacheSetDirty     = 1'b0;
    cacheBytesAccess  = '0;
    cacheDin          = '0;
    memRen            = 1'b0;
    memWen            = 1'b0;
    memBlockAddr      = '0;
    memDin            = '0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (cacheHit) begin
            cacheEn = 1'b1;
            if (wen) begin
              cacheWen         = 1'b1;
              cacheSetDirty    = 1'b1;
              cacheBytesAccess = hit_mask;
              cacheDin         = {BLOCK_WORDS{din}};
            end else begin
              dout = hit_word;
            end
          end else begin
            stall = 1'b1;
          end
        end
      end
      StWriteback: begin
        stall        = 1'b1;
        memWen       = 1'b1;
        memBlockAddr = victim_baddr_q;
        memDin       = victim_data_q;
      end
      StMemread: begin
        stall        = 1'b1;
        memRen       = 1'b1;
        memBlockAddr = req_baddr_q;
      end
      StFill: begin
        stall             = 1'b1;
        cacheEn           = 1'b1;
        cacheWen          = 1'b1;
        cacheFullBlockWen = 1'b1;
        cacheBytesAccess  = '1;
        cacheDin          = fill_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      req_baddr_q    <= '0;
      victim_baddr_q <= '0;
      victim_data_q  <= '0;
      fill_data_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req && !cacheHit) begin
            req_baddr_q    <= addr[ADDR_W-1:OFF_W];
            victim_baddr_q <= cacheVictimBAddr;
            victim_data_q  <= cacheDout;
            state_q        <= cacheDirtyBit ? StWriteback : StMemread;
          end
        end
        StWriteback: if (memWriteDone) state_q <= StMemread;
        StMemread: begin
          if (memReadReady) begin
            fill_data_q <= memDout;
            state_q     <= StFill;
          end
        end
        StFill:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Replay flag keeps the post-refill hit out of the hit count.
  logic replay_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perfHits       <= '0;
      perfMisses     <= '0;
      perfWritebacks <= '0;
      replay_q       <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        replay_q <= 1'b0;
        if (req && cacheHit && !replay_q) perfHits <= perfHits + 32'd1;
        if (req && !cacheHit) perfMisses <= perfMisses + 32'd1;
      end
      if (state_q == StWriteback && memWriteDone) perfWritebacks <= perfWritebacks + 32'd1;
      if (state_q == StFill) replay_q <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl_wb.md
# dcache_ctrl_wb

Parametrised write-back, write-allocate controller for the L1 data cache. It sits between the pipeline memory stage, the direct-mapped data/tag array and the block-wide memory port. It handles word reads, byte-masked writes, dirty-victim writeback and block refill, with block and word geometry set by parameters. Misses are serviced by stalling the pipeline and replaying the held request once the refill completes.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- WORD_BYTES, 4, bytes per word (power of 2)
- BLOCK_WORDS, 4, words per block (power of 2, ≥1)
- Derived, not overridable:
  - BLOCK_BYTES = WORD_BYTES*BLOCK_WORDS
  - BLOCK_BITS = 8*BLOCK_BYTES
  - OFF_W = log2(BLOCK_BYTES)
  - BADDR_W = ADDR_W-OFF_W

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ren, wen  in  1 each  pipeline read/write request; wen wins if both are high
- addr  in  ADDR_W  byte address
- byteSelectVector  in  WORD_BYTES  write byte enables
- din  in  8*WORD_BYTES  write data
- stall  out  1  pipeline hold
- dout  out  8*WORD_BYTES  read word
- cacheHit, cacheDirtyBit  in  1 each  tag lookup result for addr's set
- cacheVictimBAddr  in  BADDR_W  block address of the resident line
- cacheDout  in  BLOCK_BITS  resident line data
- cacheEn, cacheWen, cacheFullBlockWen, cacheSetDirty  out  1 each  array controls
- cacheBytesAccess  out  BLOCK_BYTES  byte write enables
- cacheDin  out  BLOCK_BITS  array write data
- memRen, memWen  out  1 each  memory requests
- memBlockAddr  out  BADDR_W  memory block address
- memDin  out  BLOCK_BITS  writeback data
- memReadReady, memWriteDone  in  1 each  memory completions
- memDout  in  BLOCK_BITS  refill data

## Operation
States: IDLE, WRITEBACK, MEMREAD, FILL.

**IDLE, no request:** all outputs 0.

**IDLE, request and cacheHit:**
- Read: dout = word of cacheDout selected by addr[OFF_W-1:log2(WORD_BYTES)], combinationally. cacheEn=1, stall=0.
- Write: cacheEn=cacheWen=cacheSetDirty=1. cacheBytesAccess = byteSelectVector shifted to the word slot. cacheDin = din replicated across all words. stall=0.

**IDLE, request and !cacheHit:**
- stall=1 combinationally in the same cycle.
- Latch addr block address, cacheVictimBAddr and cacheDout.
- Next state is WRITEBACK if cacheDirtyBit, else MEMREAD.

**WRITEBACK:**
- stall=1, memWen=1, memBlockAddr=latched victim address, memDin=latched victim data.
- Stays until memWriteDone is sampled high, then MEMREAD.

**MEMREAD:**
- stall=1, memRen=1, memBlockAddr=latched request block address.
- Stays until memReadReady is sampled high; memDout is latched on that edge. Next state FILL.

**FILL:**
- stall=1, cacheEn=cacheWen=cacheFullBlockWen=1, all cacheBytesAccess bits set, cacheDin=latched refill data, cacheSetDirty=0. Next state IDLE.
- The request is then replayed in IDLE and hits; a pending write is applied on replay.

Rules:
- The pipeline holds ren/wen/addr/din stable while stall=1. Changes during a miss are ignored.
- memReadReady and memWriteDone are ignored outside their own states.
- Unused states decode to IDLE.

## Timing
- Reset value of every output and register is 0; state resets to IDLE.
- Reset asserted in any state forces IDLE at the next edge, and memRen/memWen drop in that cycle's successor.
- Hit latency: 0 extra cycles.
- Clean miss: stall cycles = 1 (miss detect) + N_read + 1 (FILL), where N_read is the number of MEMREAD cycles including the ready cycle. Replay hits in the following cycle.
- Dirty miss adds N_wb WRITEBACK cycles.
- memRen and memWen are never high together. memRen/memWen and memBlockAddr are constant for the whole handshake.
- Completion asserted in the first MEMREAD or WRITEBACK cycle gives a 1-cycle state.

## Configuration
- DCACHE_PERF_CNT_EN defined: adds 32-bit outputs perfHits, perfMisses and perfWritebacks. Each wraps and is cleared by reset.
  - perfHits counts non-replay IDLE hits.
  - perfMisses counts IDLE miss detections.
  - perfWritebacks counts WRITEBACK exits.
  - A one-bit replay flag, set on FILL exit and cleared on the next IDLE cycle, excludes replays from perfHits.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset with wen=1 and a miss pending → all outputs 0 and state IDLE after 1 edge. After release, the miss sequence starts fresh.
- Read hit, BLOCK_WORDS=4, addr offset 0x8 → dout = cacheDout[95:64] in the same cycle, stall=0.
- Write hit, byteSelectVector=4'b0011, offset 0x4 → cacheBytesAccess=16'h0030, cacheSetDirty=1, stall=0.
- Clean read miss, memReadReady high on the 3rd MEMREAD cycle → stall high for exactly 5 cycles. FILL writes memDout with all 16 bytes enabled, then the replay hit returns the new word.
- Dirty write miss, victim 0x123, memWriteDone after 2 cycles → memWen for 2 cycles with memBlockAddr=0x123 and memDin=old line. Then memRen with the request block address, FILL, and a replay write that sets dirty.
- With DCACHE_PERF_CNT_EN: 3 hits, 1 clean miss, 1 dirty miss → perfHits=3, perfMisses=2, perfWritebacks=1.
